// File: rtl/spi_slave_ctrl_if.sv
// Handshake bundle between the SPI slave control FSM and its neighbours
// (edge detector / shift register on one side, address latch / data memory on the other).
interface spi_slave_ctrl_if;
  logic cs;
  logic s_pos;
  logic rw;
  logic miso_buff;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic addr_inc;
  logic busy;

  modport master (
    output cs, s_pos, rw,
    input  miso_buff, addr_we, sr_we, dm_we, addr_inc, busy
  );

  modport slave (
    input  cs, s_pos, rw,
    output miso_buff, addr_we, sr_we, dm_we, addr_inc, busy
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave control FSM: address capture, R/W decode, shift-register loads, MISO enable and
// data-memory write strobes, with optional burst frames and address auto-increment.
module spi_slave_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter bit          BURST  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_ctrl_if.slave bus
);

  localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntW = $clog2(MaxW + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StAddr   = 4'd1;
  localparam logic [3:0] StRwBit  = 4'd2;
  localparam logic [3:0] StDecode = 4'd3;
  localparam logic [3:0] StRead   = 4'd4;
  localparam logic [3:0] StRload  = 4'd5;
  localparam logic [3:0] StWrite  = 4'd6;
  localparam logic [3:0] StCommit = 4'd7;
  localparam logic [3:0] StInc    = 4'd8;
  localparam logic [3:0] StDone   = 4'd9;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            miso_buff_q, miso_buff_d;
  logic            addr_we_q, addr_we_d;
  logic            sr_we_q, sr_we_d;
  logic            dm_we_q, dm_we_d;
  logic            addr_inc_q, addr_inc_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_inc    = cnt_q + CntW'(1);
    cnt_d      = cnt_q;
    sr_we_d    = 1'b0;
    dm_we_d    = 1'b0;
    addr_inc_d = 1'b0;

    if (bus.cs) begin
      // Deselect wins over everything, dropping any partial frame.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StAddr;
        StAddr: begin
          if (bus.s_pos) begin
            if (cnt_inc == AddrLast) state_d = StRwBit;
            else                     cnt_d   = cnt_inc;
          end
        end
        StRwBit: begin
          if (bus.s_pos) state_d = StDecode;
        end
        StDecode: begin
          if (bus.rw) begin
            sr_we_d = 1'b1;
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
        end
        StRead: begin
          if (bus.s_pos) begin
            if (cnt_inc == DataLast) begin
              if (BURST) begin
                addr_inc_d = 1'b1;
                state_d    = StRload;
              end else begin
                state_d = StDone;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StRload: begin
          sr_we_d = 1'b1;
          state_d = StRead;
        end
        StWrite: begin
          if (bus.s_pos) begin
            if (cnt_inc == DataLast) state_d = StCommit;
            else                     cnt_d   = cnt_inc;
          end
        end
        StCommit: begin
          dm_we_d = 1'b1;
          state_d = BURST ? StInc : StDone;
        end
        StInc: begin
          addr_inc_d = 1'b1;
          state_d    = StWrite;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;

    miso_buff_d = (state_d == StRead) || (state_d == StRload);
    addr_we_d   = (state_d == StAddr);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      miso_buff_q <= 1'b0;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      addr_inc_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miso_buff_q <= miso_buff_d;
      addr_we_q   <= addr_we_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      addr_inc_q  <= addr_inc_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.miso_buff = miso_buff_q;
  assign bus.addr_we   = addr_we_q;
  assign bus.sr_we     = sr_we_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.addr_inc  = addr_inc_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: stimulus queues expected strobe events with their cycle,
// a negedge monitor pops and compares each strobe the selected DUT raises.
module tb_spi_slave_ctrl;

  localparam int KSr  = 0;
  localparam int KDm  = 1;
  localparam int KInc = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic cs = 1'b1;
  logic s_pos = 1'b0;
  logic rw = 1'b0;
  int   sel = 0;

  int n_checks = 0;
  int n_pass = 0;
  ev_t exp_q[$];

  spi_slave_ctrl_if if_b1 ();
  spi_slave_ctrl_if if_b0 ();
  spi_slave_ctrl_if if_w ();

  assign if_b1.cs    = (sel == 0) ? cs : 1'b1;
  assign if_b1.s_pos = (sel == 0) ? s_pos : 1'b0;
  assign if_b1.rw    = rw;
  assign if_b0.cs    = (sel == 1) ? cs : 1'b1;
  assign if_b0.s_pos = (sel == 1) ? s_pos : 1'b0;
  assign if_b0.rw    = rw;
  assign if_w.cs     = (sel == 2) ? cs : 1'b1;
  assign if_w.s_pos  = (sel == 2) ? s_pos : 1'b0;
  assign if_w.rw     = rw;

  spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(1'b1)) u_dut_b1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b1)
  );

  spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(1'b0)) u_dut_b0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b0)
  );

  spi_slave_ctrl #(.ADDR_W(15), .DATA_W(16), .BURST(1'b1)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w)
  );

  // {miso_buff, addr_we, sr_we, dm_we, addr_inc, busy} of the selected instance
  logic [5:0] m_all;
  always_comb begin
    case (sel)
      0:       m_all = {if_b1.miso_buff, if_b1.addr_we, if_b1.sr_we, if_b1.dm_we,
                        if_b1.addr_inc, if_b1.busy};
      1:       m_all = {if_b0.miso_buff, if_b0.addr_we, if_b0.sr_we, if_b0.dm_we,
                        if_b0.addr_inc, if_b0.busy};
      default: m_all = {if_w.miso_buff, if_w.addr_we, if_w.sr_we, if_w.dm_we,
                        if_w.addr_inc, if_w.busy};
    endcase
  end

  wire m_miso    = m_all[5];
  wire m_addr_we = m_all[4];
  wire m_busy    = m_all[0];
  wire [2:0] m_pulse = {m_all[1], m_all[2], m_all[3]};  // {inc, dm, sr}

  function automatic string kname(input int k);
    case (k)
      KSr:     return "sr_we";
      KDm:     return "dm_we";
      default: return "addr_inc";
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_pulse[k]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL event: got %s at cycle %0d, required no strobe", kname(k), cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind == k && e.cyc == cyc) n_pass++;
          else $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                        kname(k), cyc, kname(e.kind), e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  task automatic check_empty(input string name);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: got %0d outstanding strobes, required 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int k, input int c);
    exp_q.push_back(ev_t'{kind: k, cyc: c});
  endtask

  // n s_pos pulses, 4 clk apart; strobes expected after the last one are queued as it is issued
  task automatic spos_n(input int n, input int ka = -1, input int oa = 0,
                        input int kb = -1, input int ob = 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s_pos = 1'b1;
      if (i == n - 1) begin
        if (ka >= 0) expect_ev(ka, cyc + oa);
        if (kb >= 0) expect_ev(kb, cyc + ob);
      end
      step();
      s_pos = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state of every instance
    repeat (2) step();
    chk("rst_b1", {if_b1.miso_buff, if_b1.addr_we, if_b1.sr_we, if_b1.dm_we, if_b1.addr_inc,
                   if_b1.busy}, 0);
    chk("rst_b0", {if_b0.miso_buff, if_b0.addr_we, if_b0.sr_we, if_b0.dm_we, if_b0.addr_inc,
                   if_b0.busy}, 0);
    chk("rst_w", {if_w.miso_buff, if_w.addr_we, if_w.sr_we, if_w.dm_we, if_w.addr_inc,
                  if_w.busy}, 0);
    rst_n = 1'b1;
    step();

    // Non-burst write of one frame
    sel = 1; rw = 1'b0; cs = 1'b0;
    step();
    chk("wr_addr_we_start", m_addr_we, 1);
    chk("wr_busy_start", m_busy, 1);
    spos_n(6);
    chk("wr_addr_we_6", m_addr_we, 1);
    spos_n(1);
    chk("wr_addr_we_7", m_addr_we, 0);
    spos_n(1);
    spos_n(8, KDm, 2);
    chk("wr_done_busy", m_busy, 1);
    chk("wr_done_miso", m_miso, 0);
    check_empty("wr_strobes");
    cs = 1'b1;
    step();
    chk("wr_cs_high", m_all, 0);

    // Burst read of three frames
    sel = 0; rw = 1'b1; cs = 1'b0;
    step();
    spos_n(7);
    spos_n(1, KSr, 2);
    chk("brd_miso_decode", m_miso, 1);
    for (int f = 0; f < 3; f++) begin
      spos_n(8, KInc, 1, KSr, 2);
      chk("brd_miso_frame", m_miso, 1);
    end
    cs = 1'b1;
    step();
    chk("brd_cs_high", m_all, 0);
    check_empty("brd_strobes");

    // Burst write of two frames, then deselect mid-frame
    rw = 1'b0; cs = 1'b0;
    step();
    spos_n(8);
    spos_n(8, KDm, 2, KInc, 3);
    spos_n(8, KDm, 2, KInc, 3);
    spos_n(5);
    cs = 1'b1;
    step();
    chk("bwr_abort", m_all, 0);
    repeat (4) step();
    check_empty("bwr_strobes");

    // Widest configuration
    sel = 2; rw = 1'b0; cs = 1'b0;
    step();
    spos_n(14);
    chk("wide_addr_we_14", m_addr_we, 1);
    spos_n(1);
    chk("wide_addr_we_15", m_addr_we, 0);
    spos_n(1);
    spos_n(16, KDm, 2, KInc, 3);
    cs = 1'b1;
    step();
    chk("wide_cs_high", m_all, 0);
    check_empty("wide_strobes");

    // Asynchronous reset in the middle of a read
    sel = 1; rw = 1'b1; cs = 1'b0;
    step();
    spos_n(7);
    spos_n(1, KSr, 2);
    spos_n(3);
    chk("rrst_miso_before", m_miso, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rrst_outputs", m_all, 0);
    check_empty("rrst_strobes");
    rw = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rrst_restart_addr_we", m_addr_we, 1);
    spos_n(8);
    spos_n(8, KDm, 2);
    chk("rrst_restart_busy", m_busy, 1);
    cs = 1'b1;
    step();
    chk("rrst_cs_high", m_all, 0);
    check_empty("rrst_restart_strobes");

    // Non-burst read, then surplus s_pos while still selected
    rw = 1'b1; cs = 1'b0;
    step();
    spos_n(7);
    spos_n(1, KSr, 2);
    spos_n(8);
    chk("nrd_done_miso", m_miso, 0);
    chk("nrd_done_busy", m_busy, 1);
    spos_n(8);
    chk("nrd_extra_miso", m_miso, 0);
    chk("nrd_extra_busy", m_busy, 1);
    cs = 1'b1;
    step();
    chk("nrd_cs_high", m_all, 0);
    check_empty("nrd_strobes");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised control FSM for the SPI slave: the successor to the fixed 7-bit-address / 8-bit-data controller. Sequences address capture, R/W decode, shift-register parallel load, MISO tristate enable and data-memory write strobes for configurable address and data widths. Adds optional burst mode: multiple data frames per chip-select with automatic address increment. Sits between the sclk edge detector / shift register and the address latch / data memory.

## Interface
- ADDR_W, 7, address bits in the header (1..15)
- DATA_W, 8, bits per data frame (1..16)
- BURST, 1, 1 = frames repeat while cs low with address auto-increment; 0 = one frame per transaction
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- cs  input  1  chip select, active low (high = deselected)
- s_pos  input  1  one-clk pulse per sclk rising edge (synchronised)
- rw  input  1  shift register bit 0; 1 = read, 0 = write
- miso_buff  output  1  MISO tristate enable
- addr_we  output  1  address latch write enable
- sr_we  output  1  shift register parallel-load pulse
- dm_we  output  1  data memory write pulse
- addr_inc  output  1  address latch increment pulse (burst only)
- busy  output  1  high in any state other than IDLE

## Operation
- Reset (rst_n low, async): state IDLE, counter 0, every output 0.
- Counter width: $clog2(max(ADDR_W,DATA_W)+1); incremented only on s_pos; cleared on every state change.
- cs high (sampled any clk, any state): next state IDLE, all outputs 0, counter 0. A partially received write frame is discarded (no dm_we); overrides every other transition.
- IDLE: cs low -> ADDR.
- ADDR: addr_we=1. On ADDR_W-th s_pos -> RWBIT, addr_we drops the same edge.
- RWBIT: on next s_pos (R/W bit shifted in) -> DECODE.
- DECODE (1 clk): rw=1 -> sr_we pulse, miso_buff=1, -> READ; rw=0 -> WRITE.
- READ: miso_buff=1. On DATA_W-th s_pos: BURST=1 -> addr_inc pulse, -> RLOAD; BURST=0 -> DONE, miso_buff=0.
- RLOAD (1 clk): sr_we pulse (loads data at incremented address), -> READ.
- WRITE: on DATA_W-th s_pos -> COMMIT.
- COMMIT (1 clk): dm_we pulse. BURST=1 -> INC; BURST=0 -> DONE.
- INC (1 clk): addr_inc pulse, -> WRITE.
- DONE: all outputs 0 except busy; waits for cs high; further s_pos ignored.
- Address wrap on increment is owned by the address latch (modulo 2^ADDR_W); this block does not track it.
- s_pos arriving in a 1-clk state (DECODE/RLOAD/COMMIT/INC) is a protocol violation; not required to be counted.

## Timing
- All outputs registered; change on the clk edge after the qualifying event.
- Requirement on environment: s_pos pulses at least 4 clk apart (covers COMMIT+INC or DECODE/RLOAD gaps).
- Header-end to sr_we: 2 clk after the (ADDR_W+1)-th s_pos (RWBIT->DECODE, then pulse).
- Write frame end to dm_we: dm_we high exactly 2 clk after the DATA_W-th s_pos, for 1 clk; addr_inc 1 clk after dm_we.
- Read frame end: addr_inc 1 clk after DATA_W-th s_pos, sr_we the following clk.
- cs rising to outputs low: 1 clk. rst_n falling: immediate.
- sr_we, dm_we, addr_inc never high for more than 1 consecutive clk; dm_we and sr_we never high together.

## Test plan
- Defaults, write 0xA5 to addr 0x12 (7 addr s_pos, rw=0 bit, 8 data s_pos, cs high) -> addr_we high for exactly 7 s_pos, one dm_we pulse 2 clk after 8th data s_pos, no addr_inc with BURST=0 variant.
- BURST=1 read, 3 frames -> sr_we at DECODE, then addr_inc/sr_we pairs after frames 1,2,3; miso_buff high from DECODE until cs high.
- BURST=1 write, 2 frames -> dm_we, addr_inc, dm_we, addr_inc in order; cs high after 5th bit of frame 3 -> no third dm_we, outputs 0 within 1 clk.
- ADDR_W=15, DATA_W=16 -> counter reaches 15/16 without overflow; dm_we after 16th data s_pos.
- rst_n pulsed low mid-READ -> all outputs 0 asynchronously, busy 0, next transaction restarts from ADDR cleanly.
- BURST=0 read then extra 8 s_pos with cs low -> stays DONE, no sr_we, miso_buff 0.
